sync_fifo: RTL and testbench

- Synchronous FIFO under test, feeding the write/read scoreboard stage directly downstream.
- Shares the scoreboard's `wq`, `rq` and `wr_data` stimulus and returns `fo_data` one clock after each accepted read, which is exactly when the scoreboard compares.
- Reports occupancy and flags illegal pushes and pops so the bench can separate protocol misuse from data corruption.

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/fifo_dpram.sv | 37 +++
 rtl/sync_fifo.sv | 109 ++++++++++
 tb/tb_sync_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants, depth helper and occupancy type for the synchronous FIFO.
package sync_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PTR_W_DEF  = 4;

  function automatic int fifo_depth(input int ptr_w);
    return 1 << ptr_w;
  endfunction

  typedef logic [PTR_W_DEF:0] count_t;

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: one write port and one registered read port.
// A read and a write to the same slot in one cycle return the old entry.
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the storage array has no reset; this keeps it mappable to RAM macros,
  // and the pointers guarantee no slot is read before it is written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      // NOTE: non-blocking assignment samples mem before this edge's write lands,
      // which is what gives read-before-write on a shared slot.
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered status, occupancy count and misuse pulses.
// Optional almost_full/almost_empty flags are built when SYNC_FIFO_ALMOST_EN is defined.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PTR_W  = PTR_W_DEF
`ifdef SYNC_FIFO_ALMOST_EN
  ,
  parameter int AF_LVL = fifo_depth(PTR_W) - 2,
  parameter int AE_LVL = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wq,
  input  logic              rq,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] fo_data,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow
`ifdef SYNC_FIFO_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int             DEPTH     = fifo_depth(PTR_W);
  localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE       = (PTR_W+1)'(1);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] count_nxt;
  logic           wr_ok;
  logic           rd_ok;

  // A write into a full FIFO is legal only when a read frees a slot on the same edge.
  assign wr_ok = wq & (~full | rq);
  assign rd_ok = rq & ~empty;

  always_comb begin
    // NOTE: default assignment first so every path drives count_nxt and no latch is inferred.
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ONE;
      end
      count     <= count_nxt;
      full      <= (count_nxt == CNT_DEPTH);
      empty     <= (count_nxt == '0);
      overflow  <= wq & ~wr_ok;
      underflow <= rq & ~rd_ok;
    end
  end

`ifdef SYNC_FIFO_ALMOST_EN
  localparam logic [PTR_W:0] AF_CNT = (PTR_W+1)'(AF_LVL);
  localparam logic [PTR_W:0] AE_CNT = (PTR_W+1)'(AE_LVL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt >= AF_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
    end
  end
`endif

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_ok),
    .wr_addr (wr_ptr[PTR_W-1:0]),
    .wr_data (wr_data),
    .re      (rd_ok),
    .rd_addr (rd_ptr[PTR_W-1:0]),
    .rd_data (fo_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue model predicts accepts, status and read data.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int PTR_W  = PTR_W_DEF;
  localparam int DEPTH  = fifo_depth(PTR_W);

  logic              clk = 1'b0;
  logic              rst;
  logic              wq;
  logic              rq;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] fo_data;
  logic              full;
  logic              empty;
  count_t            count;
  logic              overflow;
  logic              underflow;
`ifdef SYNC_FIFO_ALMOST_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  sync_fifo #(
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wq        (wq),
    .rq        (rq),
    .wr_data   (wr_data),
    .fo_data   (fo_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef SYNC_FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] exp_q   [$];
  logic [DATA_W-1:0] last_fo;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_status();
    check("count", 32'(count), 32'(model_q.size()));
    check("full",  32'(full),  32'(model_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
`ifdef SYNC_FIFO_ALMOST_EN
    check("almost_full",  32'(almost_full),  32'(model_q.size() >= DEPTH - 2));
    check("almost_empty", 32'(almost_empty), 32'(model_q.size() <= 2));
`endif
  endtask

  // Drive one cycle from a negedge, predict from pre-edge model state, check #1 after the posedge.
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
    logic m_full, m_empty, w_ok, r_ok;
    m_full  = (model_q.size() == DEPTH);
    m_empty = (model_q.size() == 0);
    w_ok    = w & (~m_full | r);
    r_ok    = r & ~m_empty;
    wq      = w;
    rq      = r;
    wr_data = d;
    if (r_ok) exp_q.push_back(model_q.pop_front());
    if (w_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    check("overflow",  32'(overflow),  32'(w & ~w_ok));
    check("underflow", 32'(underflow), 32'(r & ~r_ok));
    if (r_ok) begin
      last_fo = exp_q.pop_front();
      check("fo_data", 32'(fo_data), 32'(last_fo));
    end else begin
      check("fo_hold", 32'(fo_data), 32'(last_fo));
    end
    check_status();
    @(negedge clk);
    wq = 1'b0;
    rq = 1'b0;
  endtask

  task automatic drain();
    while (model_q.size() > 0) step(1'b0, 1'b1, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    wq      = 1'b0;
    rq      = 1'b0;
    wr_data = '0;
    last_fo = '0;
    @(negedge clk);
    check("rst_fo",        32'(fo_data),   32'h0);
    check("rst_overflow",  32'(overflow),  32'h0);
    check("rst_underflow", 32'(underflow), 32'h0);
    check_status();
    rst = 1'b0;

    // Three writes then three reads.
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);

    // Fill, reject one extra write, drain without the rejected word.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'hAA);
    drain();

    // Underflow alone, then simultaneous request on empty: only the write lands.
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 8'h5A);
    drain();

    // Simultaneous write and read at full: oldest word out, new word last.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 8'h77);
    drain();

    // Interleaved stream wrapping both pointers at least twice.
    for (int i = 0; i < 40; i++) step(1'b1, (i >= 3), 8'(8'h40 + i));
    drain();
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    drain();

    // Asynchronous reset with five words resident.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hE0 + i));
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 8'hE5);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    exp_q.delete();
    last_fo = '0;
    check("async_fo", 32'(fo_data), 32'h0);
    check_status();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h99);
    step(1'b0, 1'b1, '0);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
